// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and helpers for the instruction fetch unit
package fetch_pkg;

    typedef enum logic {FETCH_RUN, FETCH_HALT} fetch_state_e;

    localparam int unsigned INSTR_BYTES = 4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    // A fetchable PC is word aligned and inside the instruction memory.
    function automatic logic pc_fetchable(input logic [31:0] pc, input logic [31:0] mem_size);
        return (pc[1:0] == 2'b00) && (pc < mem_size);
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - memory, redirect and decode-side signals of the fetch unit
interface instr_fetch_if;

    logic [31:0] imem_pc_o;
    logic [31:0] imem_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        fault_o;
    logic [31:0] fault_pc_o;

    modport master (
        output imem_pc_o, inst_valid_o, inst_o, inst_pc_o, fault_o, fault_pc_o,
        input  imem_data_i, redirect_i, redirect_pc_i, inst_ready_i
    );

    modport slave (
        input  imem_pc_o, inst_valid_o, inst_o, inst_pc_o, fault_o, fault_pc_o,
        output imem_data_i, redirect_i, redirect_pc_i, inst_ready_i
    );

endinterface

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - two-entry (output + skid) valid/ready buffer with flush
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         in_valid_i,
    input  fetch_entry_t in_data_i,
    output logic         out_valid_o,
    output fetch_entry_t out_data_o,
    input  logic         out_ready_i,
    output logic         skid_valid_o
);

    fetch_entry_t skid_data_q;
    logic         out_free;

    assign out_free = !out_valid_o || out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_o  <= 1'b0;
            skid_valid_o <= 1'b0;
            out_data_o   <= '0;
            skid_data_q  <= '0;
        end else if (flush_i) begin
            out_valid_o  <= 1'b0;
            skid_valid_o <= 1'b0;
        end else if (out_free) begin
            // Skid entry is older than the incoming one, so it moves out first.
            if (skid_valid_o) begin
                out_data_o   <= skid_data_q;
                out_valid_o  <= 1'b1;
                skid_valid_o <= in_valid_i;
                if (in_valid_i) skid_data_q <= in_data_i;
            end else begin
                out_valid_o <= in_valid_i;
                if (in_valid_i) out_data_o <= in_data_i;
            end
        end else if (in_valid_i) begin
            skid_valid_o <= 1'b1;
            skid_data_q  <= in_data_i;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC, request and fault control feeding the fetch skid buffer
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned MEM_SIZE_B = 1024
) (
    input logic           clk_i,
    input logic           rst_i,
    instr_fetch_if.master bus
);

    logic [31:0]  pc_q;
    logic [31:0]  req_pc_q;
    logic         req_q;
    fetch_state_e state_q;
    logic         fault_q;
    logic [31:0]  fault_pc_q;

    logic         out_valid;
    logic         skid_valid;
    fetch_entry_t out_data;
    fetch_entry_t resp_entry;
    logic         xfer;
    logic [1:0]   held_next;
    logic         has_room;
    logic         pc_good;

    assign xfer    = out_valid && bus.inst_ready_i;
    assign pc_good = pc_fetchable(pc_q, 32'(MEM_SIZE_B));

    // Entries held after this edge; a new request is only safe if its
    // response will still find a free slot one cycle later.
    assign held_next = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, req_q} - {1'b0, xfer};
    assign has_room  = held_next < 2'd2;

    assign resp_entry = '{instr: bus.imem_data_i, pc: req_pc_q};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q       <= RESET_PC;
            req_q      <= 1'b0;
            req_pc_q   <= '0;
            state_q    <= FETCH_RUN;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else if (bus.redirect_i) begin
            pc_q       <= bus.redirect_pc_i;
            req_q      <= 1'b0;
            state_q    <= FETCH_RUN;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else if (state_q == FETCH_RUN && !pc_good) begin
            req_q      <= 1'b0;
            state_q    <= FETCH_HALT;
            fault_q    <= 1'b1;
            fault_pc_q <= pc_q;
        end else if (state_q == FETCH_RUN && has_room) begin
            req_q    <= 1'b1;
            req_pc_q <= pc_q;
            pc_q     <= pc_q + 32'(INSTR_BYTES);
        end else begin
            req_q <= 1'b0;
        end
    end

    fetch_skid_buf u_buf (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (bus.redirect_i),
        .in_valid_i   (req_q),
        .in_data_i    (resp_entry),
        .out_valid_o  (out_valid),
        .out_data_o   (out_data),
        .out_ready_i  (bus.inst_ready_i),
        .skid_valid_o (skid_valid)
    );

    assign bus.imem_pc_o    = pc_q;
    assign bus.inst_valid_o = out_valid;
    assign bus.inst_o       = out_data.instr;
    assign bus.inst_pc_o    = out_data.pc;
    assign bus.fault_o      = fault_q;
    assign bus.fault_pc_o   = fault_pc_q;

endmodule
